// File: rtl/letter_scan_display.sv
// Four-digit letter display: captures day-letter codes, swaps them in only at scan-frame
// boundaries, decodes to 7-segment glyphs and multiplexes them onto a common-anode display.
module letter_scan_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] letter0,
  input  logic [3:0] letter1,
  input  logic [3:0] letter2,
  input  logic [3:0] letter3,
  input  logic       blink_en,
  input  logic [1:0] blink_sel,
  output logic       load_ack,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned PresW = $clog2(SCAN_DIV);
  localparam int unsigned FrmW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(SCAN_DIV - 1);
  localparam logic [FrmW-1:0]  FrmMax  = FrmW'(BLINK_FRAMES - 1);

  logic [PresW-1:0] presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [FrmW-1:0]  frame_cnt_q, frame_cnt_d;
  logic             phase_q, phase_d;
  logic [3:0][3:0]  active_q, active_d;
  logic [3:0][3:0]  pend_q, pend_d;
  logic             pvalid_q, pvalid_d;
  logic             ack_q, ack_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick, frame_end, blank;

  // Active-high gfedcba glyph for each letter code.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b0000000;
      4'd1:    g = 7'b1110111;
      4'd2:    g = 7'b1011110;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b1110001;
      4'd5:    g = 7'b1110110;
      4'd6:    g = 7'b0000110;
      4'd7:    g = 7'b1010100;
      4'd8:    g = 7'b0111111;
      4'd9:    g = 7'b1110011;
      4'd10:   g = 7'b1010000;
      4'd11:   g = 7'b1101101;
      4'd12:   g = 7'b1111000;
      4'd13:   g = 7'b0111110;
      default: g = 7'b1000000;
    endcase
    return g;
  endfunction

  assign tick      = (presc_q == PresMax);
  assign frame_end = tick && (idx_q == 2'd3);

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pvalid_d    = pvalid_q;
    ack_d       = 1'b0;

    if (frame_end) begin
      if (frame_cnt_q == FrmMax) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    if (frame_end && pvalid_q) begin
      active_d = pend_q;
      pvalid_d = 1'b0;
      ack_d    = 1'b1;
    end
    // A load on the swap cycle is applied after the swap, so it waits for the next frame.
    if (load) begin
      pend_d   = {letter3, letter2, letter1, letter0};
      pvalid_d = 1'b1;
    end

    blank = blink_en && phase_q && (idx_q == blink_sel);
    an_d  = ~(4'b1000 >> idx_q);
    seg_d = blank ? 7'h7F : ~glyph(active_q[idx_q]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      idx_q       <= 2'd0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      active_q    <= '0;
      pend_q      <= '0;
      pvalid_q    <= 1'b0;
      ack_q       <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pvalid_q    <= pvalid_d;
      ack_q       <= ack_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign load_ack = ack_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_letter_scan_display.sv
// Bench for letter_scan_display: directed and random loads/blink settings checked every cycle
// against a time-indexed reference model of the scan, swap and blink rules.
module tb_letter_scan_display;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       reset, load, blink_en, load_ack;
  logic [3:0] letter0, letter1, letter2, letter3, an;
  logic [1:0] blink_sel;
  logic [6:0] seg;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: edges since reset release, active/pending codes.
  int         e;
  logic [3:0] m_act[4];
  logic [3:0] m_pend[4];
  bit         m_valid;

  letter_scan_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .letter0  (letter0),
    .letter1  (letter1),
    .letter2  (letter2),
    .letter3  (letter3),
    .blink_en (blink_en),
    .blink_sel(blink_sel),
    .load_ack (load_ack),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:  return 7'b0000000;
      4'd1:  return 7'b1110111;
      4'd2:  return 7'b1011110;
      4'd3:  return 7'b1111001;
      4'd4:  return 7'b1110001;
      4'd5:  return 7'b1110110;
      4'd6:  return 7'b0000110;
      4'd7:  return 7'b1010100;
      4'd8:  return 7'b0111111;
      4'd9:  return 7'b1110011;
      4'd10: return 7'b1010000;
      4'd11: return 7'b1101101;
      4'd12: return 7'b1111000;
      4'd13: return 7'b0111110;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, e, got, exp);
    end
  endtask

  task automatic chk_reset();
    check("rst_an", {3'b000, an}, 7'h0F);
    check("rst_seg", seg, 7'h7F);
    check("rst_ack", {6'b0, load_ack}, 7'h00);
  endtask

  task automatic model_reset();
    e = 0;
    m_valid = 0;
    for (int k = 0; k < 4; k++) begin
      m_act[k] = 4'd0;
      m_pend[k] = 4'd0;
    end
  endtask

  task automatic set_letters(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic [3:0] d);
    letter0 = a;
    letter1 = b;
    letter2 = c;
    letter3 = d;
  endtask

  // One clock: derive expected outputs from the digit/frame position implied by elapsed time.
  task automatic step();
    int         idx_b, ph_b;
    bit         bnd;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_ack;
    idx_b = (e / SD) % 4;
    ph_b  = (e / (FRAME * BF)) % 2;
    exp_an = 4'b1111;
    exp_an[3 - idx_b] = 1'b0;
    if (blink_en && ph_b == 1 && int'(blink_sel) == idx_b) exp_seg = 7'h7F;
    else exp_seg = ~glyph(m_act[idx_b]);
    bnd = ((e + 1) % FRAME) == 0;
    exp_ack = bnd && m_valid;
    if (bnd && m_valid) begin
      m_act = m_pend;
      m_valid = 0;
    end
    if (load) begin
      m_pend[0] = letter0;
      m_pend[1] = letter1;
      m_pend[2] = letter2;
      m_pend[3] = letter3;
      m_valid = 1;
    end
    @(posedge clk);
    e++;
    #1;
    check("an", {3'b000, an}, {3'b000, exp_an});
    check("seg", seg, exp_seg);
    check("ack", {6'b0, load_ack}, {6'b0, exp_ack});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int ph);
    while (e % FRAME != ph) step();
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d);
    set_letters(a, b, c, d);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    blink_en = 1'b0;
    blink_sel = 2'd0;
    set_letters(4'd0, 4'd0, 4'd0, 4'd0);
    model_reset();
    #2;
    chk_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_reset();
    end
    @(negedge clk);
    reset = 1'b0;

    run(20);
    // "TUE " mid-frame
    run_to(6);
    do_load(4'd12, 4'd13, 4'd3, 4'd0);
    run(40);
    // MON then FRI within one frame
    run_to(2);
    do_load(4'd7, 4'd7, 4'd8, 4'd7);
    run(3);
    do_load(4'd4, 4'd10, 4'd6, 4'd0);
    run(40);
    // SAT pending, SUN loaded on the boundary cycle
    run_to(5);
    do_load(4'd11, 4'd1, 4'd12, 4'd0);
    run_to(15);
    do_load(4'd11, 4'd13, 4'd7, 4'd0);
    run(40);
    // Load on a boundary with nothing pending
    run_to(15);
    do_load(4'd14, 4'd15, 4'd14, 4'd15);
    run(40);
    // Blink digit 2, then disable
    blink_en = 1'b1;
    blink_sel = 2'd2;
    run(140);
    blink_en = 1'b0;
    run(40);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_letters(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        load = 1'b1;
      end
      if ($urandom_range(0, 31) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 63) == 0) blink_sel = 2'($urandom_range(0, 3));
      step();
      load = 1'b0;
    end
    // Reset while codes are pending
    run_to(3);
    do_load(4'd1, 4'd2, 4'd3, 4'd5);
    run(3);
    reset = 1'b1;
    #2;
    model_reset();
    chk_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_reset();
    end
    @(negedge clk);
    reset = 1'b0;
    blink_en = 1'b0;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/letter_scan_display.md
Name: letter_scan_display

Overview:
Consumer end of the 4-bit day-letter code bus produced by the watch day-setting logic. Captures four letter codes (FirstLetter..FourthLetter), decodes each to a 7-segment glyph and time-multiplexes them onto a 4-digit common-anode display. Active codes change only at scan-frame boundaries, so the display never tears. Supports blinking one digit during edit mode.

Parameters:
SCAN_DIV, 50000, clk cycles each digit is lit (min 2)
BLINK_FRAMES, 128, full 4-digit scan frames per blink half-period (min 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
load  in  1  one-cycle strobe: capture letter0..letter3 into pending register
letter0  in  4  leftmost letter code (FirstLetter)
letter1  in  4  second letter code
letter2  in  4  third letter code
letter3  in  4  rightmost letter code (FourthLetter)
blink_en  in  1  enable blinking of the digit chosen by blink_sel
blink_sel  in  2  digit to blink (0 = leftmost)
load_ack  out  1  one-cycle pulse when pending codes become active
an  out  4  anode enables, active-low; an[3] is the leftmost digit
seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (async): active codes = 0 (SPACE) x4, pending_valid=0, prescaler=0, idx=0, frame_cnt=0, blink_phase=0, an=4'b1111, seg=7'h7F, load_ack=0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler==SCAN_DIV-1). On tick, idx <= idx+1 mod 4.
- Frame boundary = tick while idx==3.
- idx k selects active letter k and drives anode an[3-k] low; the others are high.
- an/seg are registered, with 1-cycle latency from idx/active/blink state. The first cycle after reset deasserts gives an=4'b0111.
- Decode, active-high gfedcba; seg is the bitwise inverse:
  - 0 SPACE 0000000
  - 1 A 1110111
  - 2 d 1011110
  - 3 E 1111001
  - 4 F 1110001
  - 5 H 1110110
  - 6 I 0000110
  - 7 n 1010100
  - 8 O 0111111
  - 9 P 1110011
  - 10 r 1010000
  - 11 S 1101101
  - 12 t 1111000
  - 13 U 0111110
  - 14, 15 dash 1000000
- load: pending <= letter0..3 and pending_valid <= 1. A later load before the swap overwrites the pending codes (latest wins).
- At a frame boundary with pending_valid=1: active <= pending, pending_valid <= 0, and load_ack=1 for exactly the next cycle.
  - If load coincides with that boundary, the swap uses the previously pending codes. The new codes become pending (pending_valid stays 1) and swap at the following boundary.
  - If load coincides with a boundary while pending_valid=0, the codes swap at the next boundary.
- Blink:
  - frame_cnt counts frame boundaries 0..BLINK_FRAMES-1. blink_phase toggles when it wraps.
  - When blink_en=1, blink_phase=1 and idx==blink_sel, seg=7'h7F (blank) while the anode is still driven.
  - blink_en=0 never blanks. Blink counters run regardless of blink_en.
- Reset mid-frame or mid-pending: pending codes are discarded, no load_ack is produced, and the display restarts from idx 0 with SPACE.

Test Plan:
- Reset held, then released, SCAN_DIV=4 -> during reset an=1111, seg=7F. After release an cycles 0111,1011,1101,1110 every 4 clks, all with seg=7F (SPACE).
- load with codes 12,13,3,0 ("TUE ") mid-frame -> old glyphs persist to the frame end. load_ack pulses 1 clk after the boundary. Next frame shows seg=~1111000, ~0111110, ~1111001, 7F on an[3..0].
- Two loads ("MON" codes 7,7,8,7, then "FRI" codes 4,10,6,0) within one frame -> single load_ack; only FRI is displayed (~1110001, ~1010000, ~0000110, 7F).
- load on the exact boundary cycle with a prior pending "SAT" (11,1,12,0) and new "SUN" (11,13,7,0) -> SAT shown for one frame, then SUN; two load_ack pulses, one frame apart.
- BLINK_FRAMES=2, blink_en=1, blink_sel=2 -> digit an[1] is blanked for 2 frames and lit for 2 frames, alternating. Other digits are unaffected. blink_en=0 gives no blanking.
- Codes 14/15 -> seg=~1000000. Assert reset mid-pending -> no load_ack, all SPACE, an=1111 during reset.
